// File: rtl/xbar_pkg.sv
// xbar_pkg: shared types, constants and helpers for the crossbar slave model
package xbar_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK, RESP} slv_state_t;
  typedef enum logic {CMD_RD = 1'b0, CMD_WR = 1'b1} cmd_t;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  function automatic logic [15:0] lfsr_seed(input logic [15:0] s);
    return s == 16'h0 ? LFSR_DEFAULT_SEED : s;
  endfunction
  function automatic logic [7:0] draw_delay(input logic [7:0] r, input logic [8:0] m);
    return 8'({1'b0, r} % m);
  endfunction
endpackage

// File: rtl/xbar_lfsr.sv
// xbar_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) exposing its low byte
//   clk, reset_n : clock, synchronous active-low reset (reloads seed)
//   adv          : advance one step
//   rnd          : low byte of the current state
module xbar_lfsr
  import xbar_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adv,
  output logic [7:0] rnd
);
  localparam logic [15:0] S = lfsr_seed(SEED);
  logic [15:0] r;
  always_ff @(posedge clk)
    if (!reset_n) r <= S;
    else if (adv) r <= {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
  assign rnd = r[7:0];
endmodule

// File: rtl/xbar_slave.sv
// xbar_slave: crossbar responder with delayed one-cycle ack and register-array memory
//   clk, reset_n            : clock, synchronous active-low reset
//   slave_req/addr/cmd/wdata: request from master, held until ack
//   slave_ack               : one-cycle accept pulse
//   slave_resp, slave_rdata : one-cycle read response, rdata 0 otherwise
module xbar_slave
  import xbar_pkg::*;
#(
  parameter int          AW         = 8,
  parameter int          ACK_DELAY  = 2,
  parameter int          RAND_DELAY = 0,
  parameter logic [15:0] SEED       = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        slave_req,
  input  logic [31:0] slave_addr,
  input  logic        slave_cmd,
  input  logic [31:0] slave_wdata,
  output logic        slave_ack,
  output logic [31:0] slave_rdata,
  output logic        slave_resp
);
  localparam logic [8:0] DMOD = 9'(ACK_DELAY + 1);
  slv_state_t  state;
  logic [7:0]  dly_cnt;
  logic [AW-1:0] a_q;
  cmd_t        cmd_q;
  logic [31:0] wd_q;
  logic [31:0] mem [2**AW];
  logic [7:0]  rnd;
  logic [7:0]  dly;
  logic        accept;
  logic        unused;
  assign unused = ^slave_addr[31:AW];
  assign accept = state == IDLE && slave_req;
  assign dly = RAND_DELAY != 0 ? draw_delay(rnd, DMOD) : 8'(ACK_DELAY);
  xbar_lfsr #(.SEED(SEED)) u_lfsr (
    .clk(clk),
    .reset_n(reset_n),
    .adv(accept),
    .rnd(rnd)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      a_q         <= '0;
      cmd_q       <= CMD_RD;
      wd_q        <= '0;
      slave_ack   <= 1'b0;
      slave_resp  <= 1'b0;
      slave_rdata <= '0;
    end else begin
      slave_ack   <= (accept && dly == 8'd0) || (state == WAIT && dly_cnt == 8'd1);
      slave_resp  <= state == ACK && cmd_q == CMD_RD;
      slave_rdata <= (state == ACK && cmd_q == CMD_RD) ? mem[a_q] : '0;
      unique case (state)
        IDLE: if (slave_req) begin
          a_q     <= slave_addr[AW-1:0];
          cmd_q   <= cmd_t'(slave_cmd);
          wd_q    <= slave_wdata;
          dly_cnt <= dly;
          state   <= dly == 8'd0 ? ACK : WAIT;
        end
        WAIT: begin
          dly_cnt <= dly_cnt - 8'd1;
          if (dly_cnt == 8'd1) state <= ACK;
        end
        ACK:  state <= RESP;
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    else if (state == ACK && cmd_q == CMD_WR) mem[a_q] <= wd_q;
endmodule

// File: tb/tb_xbar_slave.sv
// tb_xbar_slave: randomized self-checking bench for xbar_slave against a behavioural model
module tb_xbar_slave;
  localparam int          AD [8] = '{2, 0, 5, 4, 3, 3, 3, 3};
  localparam int          RD [8] = '{0, 0, 1, 0, 1, 1, 1, 1};
  localparam logic [15:0] SD [8] = '{16'hACE1, 16'hACE1, 16'h0001, 16'hACE1,
                                     16'h0011, 16'h0022, 16'h0033, 16'h0044};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic        m_req   [8];
  logic [31:0] m_addr  [8];
  logic        m_cmd   [8];
  logic [31:0] m_wdata [8];
  logic        s_ack   [8];
  logic [31:0] s_rdata [8];
  logic        s_resp  [8];
  int ack_cnt [8];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] sb [8][256];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) for (int i = 0; i < 8; i++) if (s_ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
  for (genvar g = 0; g < 8; g++) begin : g_s
    xbar_slave #(.AW(8), .ACK_DELAY(AD[g]), .RAND_DELAY(RD[g]), .SEED(SD[g])) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .slave_req(m_req[g]),
      .slave_addr(m_addr[g]),
      .slave_cmd(m_cmd[g]),
      .slave_wdata(m_wdata[g]),
      .slave_ack(s_ack[g]),
      .slave_rdata(s_rdata[g]),
      .slave_resp(s_resp[g])
    );
  end
  function automatic int unsigned lfsr_next(input int unsigned l);
    int unsigned b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (b << 15);
  endfunction
  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) m_req[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int s = 0; s < 8; s++) for (int a = 0; a < 256; a++) sb[s][a] = '0;
  endtask
  // d = cycles of delay between accept+1 and ack (-1 on timeout); clean = no resp/rdata up to ack
  task automatic do_txn(input int s, input logic c, input logic [31:0] a, input logic [31:0] wd,
                        output int d, output logic [31:0] rd, output logic rsp, output logic clean);
    int n;
    n = 0;
    clean = 1'b1;
    @(posedge clk);
    #1;
    m_req[s] = 1'b1;
    m_cmd[s] = c;
    m_addr[s] = a;
    m_wdata[s] = wd;
    do begin
      @(negedge clk);
      n++;
      if (s_resp[s] !== 1'b0 || s_rdata[s] !== 32'h0) clean = 1'b0;
    end while (s_ack[s] !== 1'b1 && n < 300);
    if (s_ack[s] !== 1'b1) begin
      d = -1;
      m_req[s] = 1'b0;
      rd = 'x;
      rsp = 1'b0;
    end else begin
      d = n - 2;
      @(posedge clk);
      #1;
      m_req[s] = 1'b0;
      @(negedge clk);
      rsp = s_resp[s];
      rd = s_rdata[s];
    end
  endtask
  task automatic test_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) m_req[i] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (s_ack[i] !== 1'b0 || s_resp[i] !== 1'b0 || s_rdata[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_out[%0d]: ack=%b resp=%b rdata=%h want 0/0/0", i, s_ack[i], s_resp[i], s_rdata[i]);
      end
    end
    apply_reset();
    begin
      int d; logic [31:0] rd; logic rsp, cl;
      do_txn(0, 1'b0, 32'h33, 32'h0, d, rd, rsp, cl);
      n_checks++;
      if (rd !== 32'h0 || rsp !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mem: rdata=%h resp=%b want 0 1", rd, rsp);
      end
    end
  endtask
  task automatic test_write_read();
    int d; logic [31:0] rd; logic rsp, cl;
    apply_reset();
    do_txn(0, 1'b1, 32'h05, 32'h1234, d, rd, rsp, cl);
    n_checks++;
    if (d !== 2) begin n_fail++; $display("FAIL wr_delay: got %0d want 2", d); end
    n_checks++;
    if (rsp !== 1'b0 || rd !== 32'h0 || cl !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_noresp: resp=%b rdata=%h clean=%b want 0 0 1", rsp, rd, cl);
    end
    do_txn(0, 1'b0, 32'h05, 32'h0, d, rd, rsp, cl);
    n_checks++;
    if (d !== 2) begin n_fail++; $display("FAIL rd_delay: got %0d want 2", d); end
    n_checks++;
    if (rsp !== 1'b1 || rd !== 32'h1234) begin
      n_fail++;
      $display("FAIL rd_data: resp=%b rdata=%h want 1 00001234", rsp, rd);
    end
    n_checks++;
    if (cl !== 1'b1) begin n_fail++; $display("FAIL rd_early: rdata/resp nonzero before resp cycle, want clean"); end
  endtask
  task automatic test_wrap();
    int d; logic [31:0] rd; logic rsp, cl;
    do_txn(0, 1'b1, 32'h105, 32'hAA, d, rd, rsp, cl);
    do_txn(0, 1'b0, 32'h005, 32'h0, d, rd, rsp, cl);
    n_checks++;
    if (rsp !== 1'b1 || rd !== 32'hAA) begin
      n_fail++;
      $display("FAIL wrap: resp=%b rdata=%h want 1 000000aa", rsp, rd);
    end
    do_txn(0, 1'b0, 32'h7F, 32'h0, d, rd, rsp, cl);
    n_checks++;
    if (rsp !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL unwritten: resp=%b rdata=%h want 1 0", rsp, rd);
    end
  endtask
  task automatic test_back_to_back();
    int acks[$];
    int nresp, bad_rd;
    apply_reset();
    nresp = 0;
    bad_rd = 0;
    @(posedge clk);
    #1;
    m_req[1] = 1'b1;
    m_cmd[1] = 1'b0;
    m_addr[1] = 32'h20;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (s_ack[1] === 1'b1) acks.push_back(n);
      if (s_resp[1] === 1'b1) nresp++;
      if (s_rdata[1] !== 32'h0) bad_rd++;
      if (n == 30) begin
        @(posedge clk);
        #1;
        m_req[1] = 1'b0;
      end
    end
    n_checks++;
    if (acks.size() !== 10) begin n_fail++; $display("FAIL b2b_count: got %0d acks want 10", acks.size()); end
    n_checks++;
    if (nresp !== 10) begin n_fail++; $display("FAIL b2b_resp: got %0d resps want 10", nresp); end
    n_checks++;
    if (bad_rd !== 0) begin n_fail++; $display("FAIL b2b_rdata: %0d nonzero samples want 0", bad_rd); end
    if (acks.size() > 0) begin
      n_checks++;
      if (acks[0] !== 2) begin n_fail++; $display("FAIL b2b_first: ack at %0d want 2", acks[0]); end
    end
    for (int i = 1; i < acks.size(); i++) begin
      n_checks++;
      if (acks[i] - acks[i-1] !== 3) begin
        n_fail++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, acks[i] - acks[i-1]);
      end
    end
  endtask
  task automatic test_random_delay();
    localparam int N = 100;
    logic        cs [N];
    logic [31:0] as [N];
    logic [31:0] ws [N];
    int          gs [N];
    int          dl [2][N];
    logic [31:0] rl [2][N];
    int          span [2];
    for (int k = 0; k < N; k++) begin
      cs[k] = 1'($urandom_range(0, 1));
      as[k] = 32'($urandom_range(0, 7));
      ws[k] = $urandom;
      gs[k] = $urandom_range(0, 2);
    end
    for (int p = 0; p < 2; p++) begin
      int unsigned l;
      int t0;
      l = 1;
      apply_reset();
      t0 = cyc;
      for (int k = 0; k < N; k++) begin
        int d, ed; logic [31:0] rd; logic rsp, cl;
        ed = int'((l & 255) % 6);
        l = lfsr_next(l);
        repeat (gs[k]) @(posedge clk);
        do_txn(2, cs[k], as[k], ws[k], d, rd, rsp, cl);
        dl[p][k] = d;
        rl[p][k] = rd;
        n_checks++;
        if (d !== ed || d < 0 || d > 5) begin
          n_fail++;
          $display("FAIL rnd_delay[%0d.%0d]: got %0d want %0d", p, k, d, ed);
        end
        n_checks++;
        if (cs[k]) begin
          if (rsp !== 1'b0) begin n_fail++; $display("FAIL rnd_wr_resp[%0d.%0d]: resp=%b want 0", p, k, rsp); end
          sb[2][as[k][7:0]] = ws[k];
        end else if (rsp !== 1'b1 || rd !== sb[2][as[k][7:0]]) begin
          n_fail++;
          $display("FAIL rnd_rd[%0d.%0d]: resp=%b rdata=%h want 1 %h", p, k, rsp, rd, sb[2][as[k][7:0]]);
        end
      end
      span[p] = cyc - t0;
    end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (dl[1][k] !== dl[0][k] || rl[1][k] !== rl[0][k]) begin
        n_fail++;
        $display("FAIL rnd_repeat[%0d]: delay %0d rdata %h want %0d %h", k, dl[1][k], rl[1][k], dl[0][k], rl[0][k]);
      end
    end
    n_checks++;
    if (span[1] !== span[0]) begin n_fail++; $display("FAIL rnd_span: got %0d cycles want %0d", span[1], span[0]); end
  endtask
  task automatic test_reset_wait();
    int c0, d; logic [31:0] rd; logic rsp, cl;
    apply_reset();
    c0 = ack_cnt[3];
    @(posedge clk);
    #1;
    m_req[3] = 1'b1;
    m_cmd[3] = 1'b1;
    m_addr[3] = 32'h10;
    m_wdata[3] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    m_req[3] = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (ack_cnt[3] !== c0) begin n_fail++; $display("FAIL rstw_ack: got %0d acks want 0", ack_cnt[3] - c0); end
    do_txn(3, 1'b0, 32'h10, 32'h0, d, rd, rsp, cl);
    n_checks++;
    if (d !== 4) begin n_fail++; $display("FAIL rstw_delay: got %0d want 4", d); end
    n_checks++;
    if (rsp !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL rstw_mem: resp=%b rdata=%h want 1 0", rsp, rd); end
    do_txn(3, 1'b1, 32'h10, 32'h0000_BEEF, d, rd, rsp, cl);
    do_txn(3, 1'b0, 32'h10, 32'h0, d, rd, rsp, cl);
    n_checks++;
    if (rsp !== 1'b1 || rd !== 32'h0000_BEEF) begin
      n_fail++;
      $display("FAIL rstw_after: resp=%b rdata=%h want 1 0000beef", rsp, rd);
    end
  endtask
  task automatic xbar_master(input int m, input int ntx);
    for (int k = 0; k < ntx; k++) begin
      logic [31:0] a, wd, rd;
      logic c, rsp, cl;
      int s, d;
      a = {2'(m), 22'($urandom), 8'($urandom_range(0, 15))};
      s = 4 + int'(a[31:30]);
      c = 1'($urandom_range(0, 1));
      wd = $urandom;
      do_txn(s, c, a, wd, d, rd, rsp, cl);
      n_checks++;
      if (d < 0 || d > 3) begin n_fail++; $display("FAIL xb_delay[%0d.%0d]: got %0d want 0..3", s, k, d); end
      n_checks++;
      if (c) begin
        if (rsp !== 1'b0) begin n_fail++; $display("FAIL xb_wr_resp[%0d.%0d]: resp=%b want 0", s, k, rsp); end
        sb[s][a[7:0]] = wd;
      end else if (rsp !== 1'b1 || rd !== sb[s][a[7:0]]) begin
        n_fail++;
        $display("FAIL xb_rd[%0d.%0d]: resp=%b rdata=%h want 1 %h", s, k, rsp, rd, sb[s][a[7:0]]);
      end
    end
  endtask
  task automatic test_xbar();
    int c0 [4];
    apply_reset();
    for (int i = 0; i < 4; i++) c0[i] = ack_cnt[4+i];
    for (int i = 0; i < 4; i++) begin
      automatic int k = i;
      fork
        xbar_master(k, 50);
      join_none
    end
    wait fork;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ack_cnt[4+i] - c0[i] !== 50) begin
        n_fail++;
        $display("FAIL xb_acks[%0d]: got %0d want 50", i, ack_cnt[4+i] - c0[i]);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin
      m_req[i] = 1'b0;
      m_addr[i] = '0;
      m_cmd[i] = 1'b0;
      m_wdata[i] = '0;
    end
    test_reset();
    test_write_read();
    test_wrap();
    test_back_to_back();
    test_random_delay();
    test_reset_wait();
    test_xbar();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
